pll_cfg_initiator: RTL and testbench
====================================

Name: pll_cfg_initiator

Overview:
- Bus initiator that drives the PLL controller's simple register interface from the responder's opposite end.
- On a start request it performs the PLL bring-up sequence:
  - assert PLL reset and enable;
  - program the mul/div ratio;
  - pulse the ratio-update bit;
  - release reset;
  - poll the status register until lock, error or timeout.
- On failure it falls back to bypass. Sits between boot/power-management logic and the PLL controller, on the AHB clock.

Parameters:
- CTRL_ADDR, 32'h0, byte address of control register (bit0 enable, bit1 bypass, bit2 reset)
- RATIO_ADDR, 32'h4, byte address of ratio register ([7:0] div, [15:8] mul)
- STATUS_ADDR, 32'h8, byte address of status register (bit0 locked, bit1 error)
- UPDATE_ADDR, 32'hC, byte address of ratio-update register (bit0, rising edge latches ratio)
- POLL_GAP, 4, idle cycles between status reads (>=1)

Ports:
- i_clk_ahb  in  1  AHB clock
- reset_n  in  1  asynchronous active-low reset
- i_start  in  1  start bring-up, sampled only in IDLE
- i_cfg_mul  in  8  PLL multiplier
- i_cfg_div  in  8  PLL divider
- i_lock_timeout  in  32  poll budget in cycles
- o_address  out  32  bus byte address
- o_rd0_wr1  out  1  0 read, 1 write
- o_wr_data  out  32  write data
- o_valid  out  1  transaction request
- i_ready  in  1  responder accepts when high with o_valid
- i_rd_data  in  32  read data
- i_rd_valid  in  1  read data valid
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle completion pulse
- o_status  out  2  00 locked, 01 PLL error, 10 timeout; held until next start

Behaviour:
- Reset values: o_valid=0, o_address=0, o_rd0_wr1=0, o_wr_data=0, o_busy=0, o_done=0, o_status=00; FSM=IDLE; timeout counter=0.
- Reset asserted mid-sequence aborts immediately. No bus cleanup write is issued.
- Handshake:
  - A transfer is accepted in the cycle o_valid & i_ready.
  - o_address, o_rd0_wr1 and o_wr_data are held stable while o_valid=1 and not accepted.
  - o_valid drops the cycle after acceptance unless the next state issues another transfer back-to-back.
  - Only one transfer is outstanding at a time.
- Start:
  - i_start in IDLE latches mul/div and timeout, sets o_busy=1, and clears o_status.
  - A zero mul or div is replaced by 8'd1.
  - i_start while busy is ignored.
- States and transitions (each WR state issues one write, then advances on acceptance):
  - IDLE -> WR_RST: CTRL = 32'h5 (enable, reset).
  - WR_RST -> WR_RATIO: RATIO = {16'h0, mul, div}.
  - WR_RATIO -> WR_UPD0: UPDATE = 0.
  - WR_UPD0 -> WR_UPD1: UPDATE = 1, which guarantees a rising edge even after a previous run.
  - WR_UPD1 -> WR_RUN: CTRL = 32'h1. On acceptance, the timeout counter loads i_lock_timeout.
  - WR_RUN -> RD_STAT: read STATUS_ADDR; advances to WAIT_RD on acceptance.
  - WAIT_RD: waits for i_rd_valid.
    - bit1=1 -> WR_FAIL with status 01. Error has priority over locked in the same read.
    - else bit0=1 -> FIN with status 00.
    - else -> GAP.
  - GAP: counts POLL_GAP cycles, then goes to RD_STAT.
  - Timeout counter:
    - Decrements every cycle in RD_STAT, WAIT_RD and GAP, saturating at 0.
    - If it is 0 when a non-locked, non-error read returns -> WR_FAIL with status 10.
    - i_lock_timeout=0 therefore means a single poll.
    - A lock result in the same cycle as expiry counts as success.
  - WR_FAIL: CTRL = 32'h2 (bypass, disabled), then FIN.
  - FIN: o_done=1 for one cycle, o_busy=0, then IDLE.
- Latency with i_ready constantly high: 5 write cycles before the first read. First read data returns 1 cycle after acceptance.

Decomposition:
- Shared package pll_cfg_pkg holds:
  - the register address constants;
  - the CTRL bit positions;
  - the status encoding enum (ST_LOCKED, ST_PLL_ERR, ST_TIMEOUT);
  - the FSM state enum.
- One sub-module, pll_bus_master_port, owns the valid/hold/accept handshake and the read-response capture. The FSM requests a transfer and receives "accepted" and "rd_done" strobes.

Test Plan:
- mul=8'h10, div=8'h02, timeout=100, ready=1, locked on 3rd poll -> writes (0x0,0x5), (0x4,0x1002), (0xC,0), (0xC,1), (0x0,0x1) in 5 consecutive cycles; 3 reads of 0x8; o_done pulse; o_status=00.
- Status read returns 32'h3 (locked and error) -> write (0x0,0x2); o_status=01.
- Never locked, timeout=20, POLL_GAP=4 -> reads stop after the counter expires; write (0x0,0x2); o_status=10; o_done one cycle.
- i_ready held low 3 cycles during the WR_RATIO write -> o_valid, address and data stable for all 4 cycles; the sequence then continues unchanged.
- mul=0, div=0 -> RATIO write data 32'h0101. i_start pulsed during the sequence -> ignored, exactly one o_done.
- reset_n low during WAIT_RD -> all outputs return to reset values at once. A following start replays the full sequence from WR_RST.

Source files
------------

// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL configuration initiator: register map
// defaults, CTRL/STATUS bit positions, result encoding and FSM states.
package pll_cfg_pkg;

    localparam logic [31:0] CTRL_ADDR_DEF   = 32'h0;
    localparam logic [31:0] RATIO_ADDR_DEF  = 32'h4;
    localparam logic [31:0] STATUS_ADDR_DEF = 32'h8;
    localparam logic [31:0] UPDATE_ADDR_DEF = 32'hC;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_BYP_BIT  = 1;
    localparam int CTRL_RST_BIT  = 2;
    localparam int STAT_LOCK_BIT = 0;
    localparam int STAT_ERR_BIT  = 1;

    localparam logic [31:0] CTRL_BRINGUP = (32'd1 << CTRL_EN_BIT) | (32'd1 << CTRL_RST_BIT);
    localparam logic [31:0] CTRL_RUN     = (32'd1 << CTRL_EN_BIT);
    localparam logic [31:0] CTRL_FAIL    = (32'd1 << CTRL_BYP_BIT);

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'b00,
        ST_PLL_ERR = 2'b01,
        ST_TIMEOUT = 2'b10
    } pll_status_e;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_RST, S_WR_RATIO, S_WR_UPD0, S_WR_UPD1, S_WR_RUN,
        S_RD_STAT, S_WAIT_RD, S_GAP, S_WR_FAIL, S_FIN
    } pll_state_e;

    // The PLL controller treats a zero ratio field as illegal.
    function automatic logic [7:0] nonzero8(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage

// File: rtl/pll_bus_master_port.sv
// Bus master port for the PLL register interface.
// Registers one transfer request, holds it until the responder accepts,
// and tracks the single outstanding read.
//   req_*        : transfer request from the FSM (one-cycle strobe)
//   accepted     : o_valid & i_ready this cycle
//   rd_done      : read data returned for the outstanding read
//   rd_data      : read data (valid with rd_done)
//   o_* / i_*    : bus signals towards the PLL controller
module pll_bus_master_port (
    input  logic        i_clk_ahb,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        accepted,
    output logic        rd_done,
    output logic [31:0] rd_data,
    output logic [31:0] o_address,
    output logic        o_rd0_wr1,
    output logic [31:0] o_wr_data,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic [31:0] i_rd_data,
    input  logic        i_rd_valid
);

    logic rd_pending;

    assign accepted = o_valid & i_ready;
    assign rd_done  = rd_pending & i_rd_valid;
    assign rd_data  = i_rd_data;

    always_ff @(posedge i_clk_ahb or negedge reset_n) begin
        if (!reset_n) begin
            o_valid    <= 1'b0;
            o_address  <= 32'h0;
            o_rd0_wr1  <= 1'b0;
            o_wr_data  <= 32'h0;
            rd_pending <= 1'b0;
        end else begin
            // A new request may replace the current one only once it is
            // accepted, which gives back-to-back transfers with no bubble.
            if (req_valid && (!o_valid || accepted)) begin
                o_valid   <= 1'b1;
                o_address <= req_addr;
                o_rd0_wr1 <= req_wr;
                o_wr_data <= req_wdata;
            end else if (accepted) begin
                o_valid <= 1'b0;
            end

            if (accepted && !o_rd0_wr1)
                rd_pending <= 1'b1;
            else if (i_rd_valid)
                rd_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/pll_cfg_initiator.sv
// PLL bring-up sequencer: programs the PLL controller over its register
// bus, polls for lock, and falls back to bypass on error or timeout.
//   i_start / i_cfg_* / i_lock_timeout : sequence request and settings
//   o_address .. i_rd_valid            : register bus (valid/ready)
//   o_busy / o_done / o_status         : sequence progress and result
//
// state      | meaning
// -----------+--------------------------------------------------
// IDLE       | waiting for i_start
// WR_RST     | CTRL = enable + reset
// WR_RATIO   | RATIO = {mul, div}
// WR_UPD0    | UPDATE = 0
// WR_UPD1    | UPDATE = 1 (rising edge latches ratio)
// WR_RUN     | CTRL = enable, reset released; loads timeout
// RD_STAT    | status read issued
// WAIT_RD    | waiting for status data
// GAP        | idle cycles between polls
// WR_FAIL    | CTRL = bypass, disabled
// FIN        | done pulse
module pll_cfg_initiator
    import pll_cfg_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR   = CTRL_ADDR_DEF,
    parameter logic [31:0] RATIO_ADDR  = RATIO_ADDR_DEF,
    parameter logic [31:0] STATUS_ADDR = STATUS_ADDR_DEF,
    parameter logic [31:0] UPDATE_ADDR = UPDATE_ADDR_DEF,
    parameter int          POLL_GAP    = 4
) (
    input  logic        i_clk_ahb,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [7:0]  i_cfg_mul,
    input  logic [7:0]  i_cfg_div,
    input  logic [31:0] i_lock_timeout,
    output logic [31:0] o_address,
    output logic        o_rd0_wr1,
    output logic [31:0] o_wr_data,
    output logic        o_valid,
    input  logic        i_ready,
    input  logic [31:0] i_rd_data,
    input  logic        i_rd_valid,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_status
);

    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

    pll_state_e  state, next_state;
    pll_status_e status_q;
    logic [7:0]  mul_q, div_q;
    logic [31:0] tmo_cfg_q, tmo_cnt;
    logic [15:0] gap_cnt;

    logic        req_valid, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        accepted, rd_done;
    logic [31:0] rd_data;
    logic        stat_lock, stat_err, in_poll;
    logic        unused_rd_bits;

    assign stat_lock      = rd_data[STAT_LOCK_BIT];
    assign stat_err       = rd_data[STAT_ERR_BIT];
    assign unused_rd_bits = ^rd_data[31:2];
    assign in_poll        = (state == S_RD_STAT) || (state == S_WAIT_RD) || (state == S_GAP);
    assign o_status       = status_q;

    pll_bus_master_port u_port (
        .i_clk_ahb  (i_clk_ahb),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .accepted   (accepted),
        .rd_done    (rd_done),
        .rd_data    (rd_data),
        .o_address  (o_address),
        .o_rd0_wr1  (o_rd0_wr1),
        .o_wr_data  (o_wr_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .i_rd_data  (i_rd_data),
        .i_rd_valid (i_rd_valid)
    );

    always_ff @(posedge i_clk_ahb or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:     if (i_start)  next_state = S_WR_RST;
            S_WR_RST:   if (accepted) next_state = S_WR_RATIO;
            S_WR_RATIO: if (accepted) next_state = S_WR_UPD0;
            S_WR_UPD0:  if (accepted) next_state = S_WR_UPD1;
            S_WR_UPD1:  if (accepted) next_state = S_WR_RUN;
            S_WR_RUN:   if (accepted) next_state = S_RD_STAT;
            S_RD_STAT:  if (accepted) next_state = S_WAIT_RD;
            S_WAIT_RD: begin
                // Error wins over lock; lock wins over an expired budget.
                if (rd_done) begin
                    if (stat_err)            next_state = S_WR_FAIL;
                    else if (stat_lock)      next_state = S_FIN;
                    else if (tmo_cnt == 0)   next_state = S_WR_FAIL;
                    else                     next_state = S_GAP;
                end
            end
            S_GAP:      if (gap_cnt == 16'd0) next_state = S_RD_STAT;
            S_WR_FAIL:  if (accepted) next_state = S_FIN;
            S_FIN:      next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    // Requests are raised on entry to a bus state so the port can present
    // them the very next cycle.
    always_comb begin
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        o_busy    = (state != S_IDLE) && (state != S_FIN);
        o_done    = (state == S_FIN);
        if (next_state != state) begin
            case (next_state)
                S_WR_RST:   begin req_valid = 1'b1; req_wr = 1'b1; req_addr = CTRL_ADDR;   req_wdata = CTRL_BRINGUP; end
                S_WR_RATIO: begin req_valid = 1'b1; req_wr = 1'b1; req_addr = RATIO_ADDR;  req_wdata = {16'h0, mul_q, div_q}; end
                S_WR_UPD0:  begin req_valid = 1'b1; req_wr = 1'b1; req_addr = UPDATE_ADDR; req_wdata = 32'h0; end
                S_WR_UPD1:  begin req_valid = 1'b1; req_wr = 1'b1; req_addr = UPDATE_ADDR; req_wdata = 32'h1; end
                S_WR_RUN:   begin req_valid = 1'b1; req_wr = 1'b1; req_addr = CTRL_ADDR;   req_wdata = CTRL_RUN; end
                S_RD_STAT:  begin req_valid = 1'b1; req_wr = 1'b0; req_addr = STATUS_ADDR; end
                S_WR_FAIL:  begin req_valid = 1'b1; req_wr = 1'b1; req_addr = CTRL_ADDR;   req_wdata = CTRL_FAIL; end
                default:    ;
            endcase
        end
    end

    always_ff @(posedge i_clk_ahb or negedge reset_n) begin
        if (!reset_n) begin
            mul_q     <= 8'd1;
            div_q     <= 8'd1;
            tmo_cfg_q <= 32'h0;
            tmo_cnt   <= 32'h0;
            gap_cnt   <= 16'h0;
            status_q  <= ST_LOCKED;
        end else begin
            if (state == S_IDLE && i_start) begin
                mul_q     <= nonzero8(i_cfg_mul);
                div_q     <= nonzero8(i_cfg_div);
                tmo_cfg_q <= i_lock_timeout;
                status_q  <= ST_LOCKED;
            end

            if (state == S_WR_RUN && accepted)
                tmo_cnt <= tmo_cfg_q;
            else if (in_poll && tmo_cnt != 32'h0)
                tmo_cnt <= tmo_cnt - 32'h1;

            if (next_state == S_GAP && state != S_GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == S_GAP && gap_cnt != 16'h0)
                gap_cnt <= gap_cnt - 16'h1;

            if (state == S_WAIT_RD && rd_done) begin
                if (stat_err)
                    status_q <= ST_PLL_ERR;
                else if (!stat_lock && tmo_cnt == 32'h0)
                    status_q <= ST_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_pll_cfg_initiator.sv
// Scoreboard bench for pll_cfg_initiator: expected transfers and done
// results are queued by the stimulus, a monitor pops and compares them.
module tb_pll_cfg_initiator;

    logic        i_clk_ahb = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_cfg_mul = 8'h0;
    logic [7:0]  i_cfg_div = 8'h0;
    logic [31:0] i_lock_timeout = 32'h0;
    logic [31:0] o_address;
    logic        o_rd0_wr1;
    logic [31:0] o_wr_data;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] i_rd_data = 32'h0;
    logic        i_rd_valid = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [1:0]  o_status;

    pll_cfg_initiator dut (
        .i_clk_ahb      (i_clk_ahb),
        .reset_n        (reset_n),
        .i_start        (i_start),
        .i_cfg_mul      (i_cfg_mul),
        .i_cfg_div      (i_cfg_div),
        .i_lock_timeout (i_lock_timeout),
        .o_address      (o_address),
        .o_rd0_wr1      (o_rd0_wr1),
        .o_wr_data      (o_wr_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .i_rd_data      (i_rd_data),
        .i_rd_valid     (i_rd_valid),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_status       (o_status)
    );

    always #5 i_clk_ahb = ~i_clk_ahb;

    typedef struct {
        bit          is_done;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  st;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stat_script[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;

    function void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    function void push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_done = 1'b0; e.rw = 1'b1; e.addr = a; e.data = d; e.st = 2'b00;
        exp_q.push_back(e);
    endfunction

    function void push_rd();
        exp_t e;
        e.is_done = 1'b0; e.rw = 1'b0; e.addr = 32'h8; e.data = 32'h0; e.st = 2'b00;
        exp_q.push_back(e);
    endfunction

    function void push_done(input logic [1:0] st);
        exp_t e;
        e.is_done = 1'b1; e.rw = 1'b0; e.addr = 32'h0; e.data = 32'h0; e.st = st;
        exp_q.push_back(e);
    endfunction

    function void push_bringup(input logic [7:0] m, input logic [7:0] d);
        push_wr(32'h0, 32'h5);
        push_wr(32'h4, {16'h0, m, d});
        push_wr(32'hC, 32'h0);
        push_wr(32'hC, 32'h1);
        push_wr(32'h0, 32'h1);
    endfunction

    // Monitor: compares every accepted transfer and every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk_ahb);
            if (reset_n && o_valid && i_ready) begin
                if (!o_rd0_wr1) rd_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_txn: got addr=%h rw=%0d, expected no transfer", o_address, o_rd0_wr1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_done) begin
                        checks++; errors++;
                        $display("FAIL txn_order: got transfer addr=%h, expected done pulse", o_address);
                    end else begin
                        check("txn_addr", o_address, e.addr);
                        check("txn_rw", {31'h0, o_rd0_wr1}, {31'h0, e.rw});
                        if (e.rw) check("txn_wdata", o_wr_data, e.data);
                    end
                end
            end
            if (reset_n && o_done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done status=%0d, expected no done", o_status);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_done) begin
                        checks++; errors++;
                        $display("FAIL done_order: got done pulse, expected transfer addr=%h", e.addr);
                    end else begin
                        check("done_status", {30'h0, o_status}, {30'h0, e.st});
                    end
                end
            end
        end
    end

    // Responder: returns scripted status one cycle after a read is accepted.
    initial begin
        bit acc;
        forever begin
            @(negedge i_clk_ahb);
            acc = reset_n && o_valid && i_ready && !o_rd0_wr1;
            @(posedge i_clk_ahb);
            #1;
            i_rd_valid = acc;
            i_rd_data  = 32'h0;
            if (acc && stat_script.size() > 0) i_rd_data = stat_script.pop_front();
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1, "watchdog");
    end

    task automatic start_seq(input logic [7:0] m, input logic [7:0] d, input logic [31:0] t);
        @(posedge i_clk_ahb); #1;
        i_cfg_mul = m; i_cfg_div = d; i_lock_timeout = t; i_start = 1'b1;
        @(posedge i_clk_ahb); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            @(posedge i_clk_ahb);
            n++;
        end
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done in %0d cycles, expected done", name, n);
        end
        @(negedge i_clk_ahb);
        check({name, "_done_1cyc"}, {31'h0, o_done}, 32'h0);
        check({name, "_busy_off"}, {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        int r0;
        int d0;
        int n;

        // Reset values
        repeat (3) @(posedge i_clk_ahb);
        #1;
        check("rst_valid",  {31'h0, o_valid},   32'h0);
        check("rst_addr",   o_address,          32'h0);
        check("rst_rw",     {31'h0, o_rd0_wr1}, 32'h0);
        check("rst_wdata",  o_wr_data,          32'h0);
        check("rst_busy",   {31'h0, o_busy},    32'h0);
        check("rst_done",   {31'h0, o_done},    32'h0);
        check("rst_status", {30'h0, o_status},  32'h0);
        reset_n = 1'b1;

        // Lock on third poll, back-to-back writes then first read
        stat_script = '{32'h0, 32'h0, 32'h1};
        push_bringup(8'h10, 8'h02);
        repeat (3) push_rd();
        push_done(2'b00);
        r0 = rd_cnt;
        start_seq(8'h10, 8'h02, 32'd100);
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk_ahb);
            check("s1_b2b_valid", {31'h0, o_valid}, 32'h1);
            check("s1_b2b_rw", {31'h0, o_rd0_wr1}, (i < 5) ? 32'h1 : 32'h0);
        end
        wait_done("s1");
        check("s1_reads", rd_cnt - r0, 32'd3);
        check("s1_status", {30'h0, o_status}, 32'h0);

        // Locked and error together: error wins
        stat_script = '{32'h3};
        push_bringup(8'h10, 8'h02);
        push_rd();
        push_wr(32'h0, 32'h2);
        push_done(2'b01);
        start_seq(8'h10, 8'h02, 32'd100);
        wait_done("s2");
        check("s2_status", {30'h0, o_status}, 32'h1);

        // Never locked, timeout 20: five polls then bypass
        stat_script.delete();
        push_bringup(8'h10, 8'h02);
        repeat (5) push_rd();
        push_wr(32'h0, 32'h2);
        push_done(2'b10);
        r0 = rd_cnt;
        start_seq(8'h10, 8'h02, 32'd20);
        wait_done("s3");
        check("s3_reads", rd_cnt - r0, 32'd5);
        check("s3_status", {30'h0, o_status}, 32'h2);

        // Ready low 3 cycles during the ratio write
        stat_script = '{32'h1};
        push_bringup(8'h21, 8'h03);
        push_rd();
        push_done(2'b00);
        start_seq(8'h21, 8'h03, 32'd100);
        @(posedge i_clk_ahb); #1;
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk_ahb);
            check("s4_hold_valid", {31'h0, o_valid}, 32'h1);
            check("s4_hold_addr", o_address, 32'h4);
            check("s4_hold_data", o_wr_data, 32'h2103);
            @(posedge i_clk_ahb); #1;
        end
        i_ready = 1'b1;
        wait_done("s4");
        check("s4_status", {30'h0, o_status}, 32'h0);

        // Zero ratio fields and a start pulse while busy
        stat_script = '{32'h1};
        push_bringup(8'h01, 8'h01);
        push_rd();
        push_done(2'b00);
        d0 = done_cnt;
        start_seq(8'h00, 8'h00, 32'd100);
        repeat (2) @(posedge i_clk_ahb);
        #1;
        start_seq(8'h55, 8'h66, 32'd0);
        wait_done("s5");
        repeat (12) @(posedge i_clk_ahb);
        check("s5_one_done", done_cnt - d0, 32'd1);

        // Zero budget: single poll, no lock -> timeout
        stat_script.delete();
        push_bringup(8'h10, 8'h02);
        push_rd();
        push_wr(32'h0, 32'h2);
        push_done(2'b10);
        start_seq(8'h10, 8'h02, 32'd0);
        wait_done("s6a");
        check("s6a_status", {30'h0, o_status}, 32'h2);

        // Zero budget with lock on the expiring poll -> success
        stat_script = '{32'h1};
        push_bringup(8'h10, 8'h02);
        push_rd();
        push_done(2'b00);
        start_seq(8'h10, 8'h02, 32'd0);
        wait_done("s6b");
        check("s6b_status", {30'h0, o_status}, 32'h0);

        // Reset in WAIT_RD, then a full replay
        stat_script = '{32'h0};
        push_bringup(8'h10, 8'h02);
        push_rd();
        r0 = rd_cnt;
        start_seq(8'h10, 8'h02, 32'd100);
        n = 0;
        while (rd_cnt == r0 && n < 200) begin
            @(negedge i_clk_ahb);
            n++;
        end
        if (rd_cnt == r0) begin
            checks++; errors++;
            $display("FAIL s7_read_wait: got no status read, expected one");
        end
        @(posedge i_clk_ahb); #1;
        reset_n = 1'b0;
        #1;
        check("s7_rst_valid",  {31'h0, o_valid},   32'h0);
        check("s7_rst_addr",   o_address,          32'h0);
        check("s7_rst_rw",     {31'h0, o_rd0_wr1}, 32'h0);
        check("s7_rst_wdata",  o_wr_data,          32'h0);
        check("s7_rst_busy",   {31'h0, o_busy},    32'h0);
        check("s7_rst_done",   {31'h0, o_done},    32'h0);
        check("s7_rst_status", {30'h0, o_status},  32'h0);
        check("s7_queue_used", exp_q.size(), 32'd0);
        repeat (2) @(posedge i_clk_ahb);
        #1;
        stat_script = '{32'h1};
        reset_n = 1'b1;
        push_bringup(8'h10, 8'h02);
        push_rd();
        push_done(2'b00);
        start_seq(8'h10, 8'h02, 32'd100);
        wait_done("s7");
        check("s7_status", {30'h0, o_status}, 32'h0);

        repeat (4) @(posedge i_clk_ahb);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
